// File: rtl/seq_controller_pkg.sv
// Shared definitions for the sequencing controller: opcodes, register and
// ALU control codes, FSM state encoding and default widths.
package seq_controller_pkg;

  localparam int PC_W     = 5;
  localparam int PROG_LEN = 16;
  localparam int OP_W     = 4;
  localparam int CTRL_W   = 4;

  // Register control codes for the X/Y/Z registers
  localparam logic [3:0] REG_HOLD   = 4'd0;
  localparam logic [3:0] REG_LOAD   = 4'd1;
  localparam logic [3:0] REG_SHIFTR = 4'd2;
  localparam logic [3:0] REG_SHIFTL = 4'd3;
  localparam logic [3:0] REG_CLEAR  = 4'd4;

  // ALU select codes
  localparam logic [3:0] ALU_ADD = 4'd0;

  // Program opcodes; 5..14 execute as NOPs
  localparam logic [3:0] OP_CLEARLD = 4'd0;
  localparam logic [3:0] OP_ADDLD   = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_SHTR    = 4'd3;
  localparam logic [3:0] OP_DISP    = 4'd4;
  localparam logic [3:0] OP_HALT    = 4'd15;

  // Controller states; WAIT is only reachable in single-step builds
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: instruction register -> X/Y/Z control codes
// and ALU select. The parent registers these values for the EXEC cycle.
module seq_decode
  import seq_controller_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int CTRL_W = 4
) (
  input  logic [OP_W-1:0]   ir_i,
  output logic [CTRL_W-1:0] tx_o,
  output logic [CTRL_W-1:0] ty_o,
  output logic [CTRL_W-1:0] tz_o,
  output logic [CTRL_W-1:0] tula_o
);

  // Opcode lookup; anything unlisted (NOPs and HALT) leaves every register on HOLD
  always_comb begin
    tx_o   = REG_HOLD;
    ty_o   = REG_HOLD;
    tz_o   = REG_HOLD;
    tula_o = ALU_ADD;
    case (ir_i)
      OP_CLEARLD: begin
        tx_o = REG_LOAD;
        ty_o = REG_CLEAR;
        tz_o = REG_CLEAR;
      end
      OP_ADDLD: begin
        tx_o = REG_LOAD;
        ty_o = REG_LOAD;
      end
      OP_ADD:  ty_o = REG_LOAD;
      OP_SHTR: ty_o = REG_SHIFTR;
      OP_DISP: tz_o = REG_LOAD;
      default: begin
        tx_o = REG_HOLD;
        ty_o = REG_HOLD;
        tz_o = REG_HOLD;
      end
    endcase
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle sequencing controller for the X/Y/Z register + adder datapath.
// Each instruction takes a FETCH cycle (latch opcode) and an EXEC cycle in
// which the registered control codes are valid for the whole cycle.
// Optional build macro: SEQ_CONTROLLER_SINGLE_STEP_EN adds a step input and a
// WAIT state between instructions.
module seq_controller
  import seq_controller_pkg::*;
#(
  parameter int PC_W     = 5,
  parameter int PROG_LEN = 16,
  parameter int OP_W     = 4,
  parameter int CTRL_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [OP_W-1:0]   op_in,
  output logic [PC_W-1:0]   pc,
  output logic [CTRL_W-1:0] tx,
  output logic [CTRL_W-1:0] ty,
  output logic [CTRL_W-1:0] tz,
  output logic [CTRL_W-1:0] tula,
  output logic              busy,
  output logic              done,
  output logic [PC_W-1:0]   instr_cnt
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] CNT_MAX = {PC_W{1'b1}};

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [OP_W-1:0]   ir_q, ir_d;
  logic [PC_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0] tx_q, tx_d, ty_q, ty_d, tz_q, tz_d, tula_q, tula_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [CTRL_W-1:0] dec_tx_s, dec_ty_s, dec_tz_s, dec_tula_s;
  logic              last_s;

  // Decode the opcode about to be held in ir so codes register on entry to EXEC
  seq_decode #(
    .OP_W   (OP_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .ir_i   (ir_d),
    .tx_o   (dec_tx_s),
    .ty_o   (dec_ty_s),
    .tz_o   (dec_tz_s),
    .tula_o (dec_tula_s)
  );

  assign last_s = (ir_q == OP_HALT) || (pc_q == LAST_PC);

  // State, datapath-control and status registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      tx_q    <= REG_HOLD;
      ty_q    <= REG_HOLD;
      tz_q    <= REG_HOLD;
      tula_q  <= ALU_ADD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      tz_q    <= tz_d;
      tula_q  <= tula_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: sequencing, pc advance, opcode latch and instruction count
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        ir_d    = op_in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          pc_d = pc_q + 1'b1;
`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
          state_d = ST_WAIT;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_WAIT: begin
`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
        if (step) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: codes only in EXEC, HOLD everywhere else; status from next state
  always_comb begin
    tx_d   = REG_HOLD;
    ty_d   = REG_HOLD;
    tz_d   = REG_HOLD;
    tula_d = ALU_ADD;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_FETCH: busy_d = 1'b1;
      ST_EXEC: begin
        busy_d = 1'b1;
        tx_d   = dec_tx_s;
        ty_d   = dec_ty_s;
        tz_d   = dec_tz_s;
        tula_d = dec_tula_s;
      end
      ST_WAIT: busy_d = 1'b1;
      ST_DONE: done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  assign pc        = pc_q;
  assign tx        = tx_q;
  assign ty        = ty_q;
  assign tz        = tz_q;
  assign tula      = tula_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: a reference model expands each program
// into the expected per-cycle output trace; a monitor compares every cycle.
module tb_seq_controller;

`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step;
  logic [3:0] op_in;
  logic [4:0] pc;
  logic [3:0] tx, ty, tz, tula;
  logic       busy, done;
  logic [4:0] instr_cnt;
  logic [3:0] mem [16];

  typedef struct packed {
    logic [4:0] pc;
    logic [3:0] tx, ty, tz, tula;
    logic       busy, done;
    logic [4:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0;
  int errors = 0;

  seq_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
    .step      (step),
`endif
    .op_in     (op_in),
    .pc        (pc),
    .tx        (tx),
    .ty        (ty),
    .tz        (tz),
    .tula      (tula),
    .busy      (busy),
    .done      (done),
    .instr_cnt (instr_cnt)
  );

  assign op_in = mem[pc[3:0]];

  always #5 clk = ~clk;

  function automatic obs_t mk(input int p, input int x, input int y, input int z,
                              input int b, input int d, input int c);
    obs_t o;
    o.pc = 5'(p); o.tx = 4'(x); o.ty = 4'(y); o.tz = 4'(z); o.tula = 4'd0;
    o.busy = 1'(b); o.done = 1'(d); o.cnt = 5'(c);
    return o;
  endfunction

  // Reference table: opcode -> (X, Y, Z) codes with HOLD=0 LOAD=1 SHIFTR=2 CLEAR=4
  task automatic ref_codes(input int op, output int x, output int y, output int z);
    case (op)
      0: begin x = 1; y = 4; z = 4; end
      1: begin x = 1; y = 1; z = 0; end
      2: begin x = 0; y = 1; z = 0; end
      3: begin x = 0; y = 2; z = 0; end
      4: begin x = 0; y = 0; z = 1; end
      default: begin x = 0; y = 0; z = 0; end
    endcase
  endtask

  // Expand the current program into the expected cycle trace from start to DONE
  task automatic push_run();
    int p = 0, cnt = 0, x, y, z;
    bit fin = 1'b0;
    while (!fin) begin
      exp_q.push_back(mk(p, 0, 0, 0, 1, 0, cnt));
      ref_codes(int'(mem[p]), x, y, z);
      exp_q.push_back(mk(p, x, y, z, 1, 0, cnt));
      cnt = (cnt < 31) ? cnt + 1 : 31;
      if (mem[p] == 4'd15 || p == 15) begin
        fin = 1'b1;
      end else begin
        p++;
        if (STEP_MODE) exp_q.push_back(mk(p, 0, 0, 0, 1, 0, cnt));
      end
    end
    exp_q.push_back(mk(p, 0, 0, 0, 0, 1, cnt));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: one trace entry compared per cycle, sampled just after the rising edge
  initial begin
    obs_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0 && !rst) begin
        e = exp_q.pop_front();
        got = '{pc: pc, tx: tx, ty: ty, tz: tz, tula: tula, busy: busy, done: done, cnt: instr_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL trace @%0t: got pc=%0d tx=%0d ty=%0d tz=%0d tula=%0d busy=%0b done=%0b cnt=%0d expected pc=%0d tx=%0d ty=%0d tz=%0d tula=%0d busy=%0b done=%0b cnt=%0d",
                   $time, got.pc, got.tx, got.ty, got.tz, got.tula, got.busy, got.done, got.cnt,
                   e.pc, e.tx, e.ty, e.tz, e.tula, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic launch();
    @(negedge clk);
    push_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  task automatic rand_prog();
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len2, n;
    rst = 1'b1; start = 1'b0; step = STEP_MODE;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    #12;
    chk("reset pc", 32'(pc), 32'd0);
    chk("reset codes", {tx, ty, tz, tula}, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle done", 32'(done), 32'd0);

    // Directed program CLEARLD, ADDLD, ADD, SHTR, DISP, HALT
    mem[0] = 4'd0; mem[1] = 4'd1; mem[2] = 4'd2; mem[3] = 4'd3; mem[4] = 4'd4; mem[5] = 4'd15;
    launch();
    @(negedge clk);
    chk("prog1 done", 32'(done), 32'd1);
    chk("prog1 pc", 32'(pc), 32'd5);
    chk("prog1 cnt", 32'(instr_cnt), 32'd6);

    // Sixteen ADDs: runs to the last address without wrapping
    for (int i = 0; i < 16; i++) mem[i] = 4'd2;
    launch();
    repeat (2) @(negedge clk);
    chk("full pc", 32'(pc), 32'd15);
    chk("full cnt", 32'(instr_cnt), 32'd16);
    chk("full done", 32'(done), 32'd1);

    // NOP opcode 7 at address 1
    rand_prog();
    mem[0] = 4'd1; mem[1] = 4'd7; mem[2] = 4'd3; mem[3] = 4'd15;
    launch();

    // start held high: ignored while busy, restarts from DONE
    rand_prog();
    @(negedge clk);
    push_run();
    n = exp_q.size();
    push_run();
    len2 = exp_q.size() - n;
    start = 1'b1;
    n = 0;
    while (exp_q.size() > len2 - 1 && n < 300) begin
      @(posedge clk); #2; n++;
    end
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset during EXEC of ADDLD
    mem[0] = 4'd1;
    @(negedge clk);
    push_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #3;
    chk("pre-reset tx", 32'(tx), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset codes", {tx, ty, tz, tula}, 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset pc", 32'(pc), 32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle busy", 32'(busy), 32'd0);
    rand_prog();
    launch();

    // Randomised programs
    for (int r = 0; r < 10; r++) begin
      rand_prog();
      launch();
    end

`ifdef SEQ_CONTROLLER_SINGLE_STEP_EN
    // Single-step: stall in WAIT until a step pulse arrives
    for (int i = 0; i < 16; i++) mem[i] = 4'd2;
    step = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("step wait pc", 32'(pc), 32'd1);
    chk("step wait busy", 32'(busy), 32'd1);
    chk("step wait cnt", 32'(instr_cnt), 32'd1);
    step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (4) @(negedge clk);
    chk("step one pc", 32'(pc), 32'd2);
    chk("step one cnt", 32'(instr_cnt), 32'd2);
    step = 1'b1;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("step final done", 32'(done), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
